// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto an 8-bit LFSR byte stream, flywheels while locked and flags mismatches.
// Define LFSR_CHECKER_ERRCNT_EN to build the saturating err_count register and honour clr_err.
module lfsr_checker #(
  parameter int POLY_SEL = 0,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  input  logic        clr_err,
  output logic        locked,
  output logic        err_pulse,
  output logic [15:0] err_count,
  output logic [1:0]  fsm_state
);

  // Handshake: data_valid alone qualifies data_in in its cycle; there is no backpressure,
  // so every valid byte is consumed and invalid cycles leave all state untouched.

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  state_t     state_q, state_d;
  logic [7:0] pred_q, pred_d;
  logic [3:0] match_q, match_d, match_inc;
  logic [3:0] miss_q, miss_d, miss_inc;
  logic       err_d;

  function automatic logic [7:0] step(input logic [7:0] s);
    if (POLY_SEL == 0) return {s[6:0], s[7] ^ s[6] ^ s[5] ^ s[3]};
    else               return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[2]};
  endfunction

  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    match_d   = match_q;
    miss_d    = miss_q;
    err_d     = 1'b0;
    match_inc = match_q + 4'd1;
    miss_inc  = miss_q + 4'd1;
    if (data_valid) begin
      case (state_q)
        SYNC: begin
          if (data_in != 8'h00) begin
            pred_d  = step(data_in);
            match_d = 4'd0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (data_in == pred_q) begin
            pred_d  = step(data_in);
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else if (data_in != 8'h00) begin
            pred_d  = step(data_in);
            match_d = 4'd0;
          end else begin
            state_d = SYNC;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances from itself, never from the received byte.
          pred_d = step(pred_q);
          if (data_in == pred_q) begin
            miss_d = 4'd0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_inc;
            if (miss_inc == LOSS_N) state_d = SYNC;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SYNC;
      pred_q    <= 8'h00;
      match_q   <= 4'd0;
      miss_q    <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_d;
    end
  end

  assign fsm_state = state_q;

`ifdef LFSR_CHECKER_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Clear has priority over a coincident error; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 err_cnt_q <= 16'h0000;
    else if (clr_err)                        err_cnt_q <= 16'h0000;
    else if (err_d && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign err_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: instance a (POLY_SEL=0, 4/3) runs the directed scenarios,
// instance b (POLY_SEL=1, 1/15) drives a long error stream into counter saturation.
module tb_lfsr_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        a_dv, a_clr, b_dv, b_clr;
  logic [7:0]  a_din, b_din;
  logic        a_locked, a_pulse, b_locked, b_pulse;
  logic [15:0] a_cnt, b_cnt;
  logic [1:0]  a_state, b_state;

  lfsr_checker #(.POLY_SEL(0), .LOCK_CNT(4), .LOSS_CNT(3)) dut_a (
    .clk(clk), .rst(rst_a), .data_valid(a_dv), .data_in(a_din), .clr_err(a_clr),
    .locked(a_locked), .err_pulse(a_pulse), .err_count(a_cnt), .fsm_state(a_state)
  );

  lfsr_checker #(.POLY_SEL(1), .LOCK_CNT(1), .LOSS_CNT(15)) dut_b (
    .clk(clk), .rst(rst_b), .data_valid(b_dv), .data_in(b_din), .clr_err(b_clr),
    .locked(b_locked), .err_pulse(b_pulse), .err_count(b_cnt), .fsm_state(b_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] exp_a[$];
  logic [17:0] exp_b[$];
  string       nm_a[$];
  string       nm_b[$];
  logic        a_chk = 1'b0, b_chk = 1'b0;
  logic        a_pend = 1'b0, b_pend = 1'b0;

  function automatic logic [15:0] ec(input int x);
`ifdef LFSR_CHECKER_ERRCNT_EN
    return 16'(x);
`else
    return 16'h0000 & 16'(x);
`endif
  endfunction

  function automatic logic [7:0] step1(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[2]};
  endfunction

  task automatic cmp(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got locked=%0b pulse=%0b cnt=%h, want locked=%0b pulse=%0b cnt=%h",
               name, act[17], act[16], act[15:0], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive_a(input string name, input logic v, input logic [7:0] d, input logic c,
                         input logic el, input logic ep, input logic [15:0] ecnt);
    @(posedge clk); #1;
    a_dv = v; a_din = d; a_clr = c; a_chk = 1'b1;
    exp_a.push_back({el, ep, ecnt});
    nm_a.push_back(name);
  endtask

  task automatic quiet_a();
    @(posedge clk); #1;
    a_dv = 1'b0; a_din = 8'h00; a_clr = 1'b0; a_chk = 1'b0;
  endtask

  task automatic drive_b(input string name, input logic v, input logic [7:0] d, input logic c,
                         input logic el, input logic ep, input logic [15:0] ecnt);
    @(posedge clk); #1;
    b_dv = v; b_din = d; b_clr = c; b_chk = 1'b1;
    exp_b.push_back({el, ep, ecnt});
    nm_b.push_back(name);
  endtask

  task automatic push_b(input logic [7:0] d);
    @(posedge clk); #1;
    b_dv = 1'b1; b_din = d; b_clr = 1'b0; b_chk = 1'b0;
  endtask

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    a_pend <= a_chk;
    b_pend <= b_chk;
  end

  always @(negedge clk) begin
    logic [17:0] e;
    string       n;
    if (a_pend) begin
      if (exp_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL underflow_a: got empty queue, want an expected entry");
      end else begin
        e = exp_a.pop_front();
        n = nm_a.pop_front();
        cmp(n, {a_locked, a_pulse, a_cnt}, e);
      end
    end
    if (b_pend) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL underflow_b: got empty queue, want an expected entry");
      end else begin
        e = exp_b.pop_front();
        n = nm_b.pop_front();
        cmp(n, {b_locked, b_pulse, b_cnt}, e);
      end
    end
  end

  // ---------------- sequences ----------------
  task automatic seq_a();
    drive_a("lock_01", 1, 8'h01, 0, 0, 0, ec(0));
    drive_a("lock_02", 1, 8'h02, 0, 0, 0, ec(0));
    drive_a("lock_04", 1, 8'h04, 0, 0, 0, ec(0));
    drive_a("lock_08", 1, 8'h08, 0, 0, 0, ec(0));
    drive_a("lock_11", 1, 8'h11, 0, 1, 0, ec(0));
    drive_a("idle_locked", 0, 8'h00, 0, 1, 0, ec(0));
    drive_a("fly_bad_23", 1, 8'h23, 0, 1, 1, ec(1));
    drive_a("fly_good_45", 1, 8'h45, 0, 1, 0, ec(1));
    drive_a("idle_no_pulse", 0, 8'h00, 0, 1, 0, ec(1));
    drive_a("clr_on_match_8b", 1, 8'h8B, 1, 1, 0, ec(0));
    drive_a("loss_miss1", 1, 8'hFF, 0, 1, 1, ec(1));
    drive_a("loss_miss2", 1, 8'hFF, 0, 1, 1, ec(2));
    drive_a("loss_miss3", 1, 8'hFF, 0, 0, 1, ec(3));
    drive_a("idle_unlocked", 0, 8'h00, 0, 0, 0, ec(3));
    drive_a("sync_zero1", 1, 8'h00, 0, 0, 0, ec(3));
    drive_a("sync_zero2", 1, 8'h00, 0, 0, 0, ec(3));
    drive_a("reseed_01", 1, 8'h01, 0, 0, 0, ec(3));
    drive_a("reseed_02", 1, 8'h02, 0, 0, 0, ec(3));
    drive_a("reseed_bad_05", 1, 8'h05, 0, 0, 0, ec(3));
    drive_a("reseed_0a", 1, 8'h0A, 0, 0, 0, ec(3));
    drive_a("reseed_15", 1, 8'h15, 0, 0, 0, ec(3));
    drive_a("reseed_2a_nolock", 1, 8'h2A, 0, 0, 0, ec(3));
    drive_a("reseed_54_lock", 1, 8'h54, 0, 1, 0, ec(3));
    drive_a("clr_with_err", 1, 8'h00, 1, 1, 1, ec(0));
    drive_a("after_clr", 0, 8'h00, 0, 1, 0, ec(0));
    quiet_a();
    // Asynchronous reset between edges while locked.
    @(negedge clk); #2;
    rst_a = 1'b1;
    #1;
    cmp("async_rst_outputs", {a_locked, a_pulse, a_cnt}, 18'h0);
    cmp("async_rst_state", 18'(a_state), 18'h0);
    @(negedge clk);
    rst_a = 1'b0;
    drive_a("post_rst_01", 1, 8'h01, 0, 0, 0, ec(0));
    drive_a("verify_zero_to_sync", 1, 8'h00, 0, 0, 0, ec(0));
    drive_a("resync_02", 1, 8'h02, 0, 0, 0, ec(0));
    drive_a("resync_04", 1, 8'h04, 0, 0, 0, ec(0));
    drive_a("resync_08", 1, 8'h08, 0, 0, 0, ec(0));
    drive_a("resync_11", 1, 8'h11, 0, 0, 0, ec(0));
    drive_a("resync_22_lock", 1, 8'h22, 0, 1, 0, ec(0));
    quiet_a();
  endtask

  task automatic seq_b();
    logic [7:0] pb;
    drive_b("b_seed_01", 1, 8'h01, 0, 0, 0, ec(0));
    drive_b("b_lock_02", 1, 8'h02, 0, 1, 0, ec(0));
    drive_b("b_poly1_04", 1, 8'h04, 0, 1, 0, ec(0));
    drive_b("b_poly1_09", 1, 8'h09, 0, 1, 0, ec(0));
    drive_b("b_poly1_12", 1, 8'h12, 0, 1, 0, ec(0));
    pb = 8'h25;
    for (int g = 0; g < 4681; g++) begin
      for (int k = 0; k < 14; k++) begin
        push_b(pb ^ 8'h01);
        pb = step1(pb);
      end
      push_b(pb);
      pb = step1(pb);
    end
    drive_b("b_cnt_fffe", 0, 8'h00, 0, 1, 0, ec(65534));
    drive_b("b_cnt_ffff", 1, pb ^ 8'h01, 0, 1, 1, ec(65535));
    pb = step1(pb);
    drive_b("b_sat_hold", 1, pb ^ 8'h01, 0, 1, 1, ec(65535));
    pb = step1(pb);
    drive_b("b_sat_match", 1, pb, 0, 1, 0, ec(65535));
    pb = step1(pb);
    drive_b("b_clr_with_err", 1, pb ^ 8'h01, 1, 1, 1, ec(0));
    drive_b("b_after_clr", 0, 8'h00, 0, 1, 0, ec(0));
    @(posedge clk); #1;
    b_dv = 1'b0; b_clr = 1'b0; b_chk = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_dv = 1'b0; a_din = 8'h00; a_clr = 1'b0;
    b_dv = 1'b0; b_din = 8'h00; b_clr = 1'b0;
    #3;
    cmp("reset_a", {a_locked, a_pulse, a_cnt}, 18'h0);
    cmp("reset_b", {b_locked, b_pulse, b_cnt}, 18'h0);
    cmp("reset_state_a", 18'(a_state), 18'h0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    fork
      seq_a();
      seq_b();
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("drain_a", 18'(exp_a.size()), 18'h0);
    cmp("drain_b", 18'(exp_b.size()), 18'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by 2000000, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
